// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Start/done handshake plus operand and result buses of the bit-serial
//   subtractor. The controller side uses the master modport, the arithmetic
//   unit uses the slave modport.
//
//   start   master->slave  request, accepted only when the unit is idle
//   a, b    master->slave  minuend / subtrahend, sampled on the accepting edge
//   busy    slave->master  high while an operation is in flight (RUN, DONE)
//   done    slave->master  one-cycle pulse, diff/borrow valid
//   diff    slave->master  a - b mod 2^WIDTH
//   borrow  slave->master  1 iff a < b (unsigned)
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit unsigned subtractor, LSB first, one bit per clock.
//   A single full subtractor and one borrow flip-flop process the operands
//   as they shift out of two shift registers; result bits shift into the
//   diff register from the MSB end, so after WIDTH RUN edges diff holds the
//   complete result in its natural bit order.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    serial_subtractor_if.slave (start, a, b, busy, done, diff, borrow)
//
//   Timing: start accepted at edge E0 (IDLE only), RUN edges E1..E_WIDTH,
//   done high for the single cycle after E_WIDTH, back in IDLE after the
//   next edge. Minimum start-to-start spacing is WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  // Counter must index 0..WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH-1:0] diff_shift;
  logic             borrow_ff;
  logic             borrow_r;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             borrow_next;
  logic             last_bit;

  // -------------------------------------------------------------------------
  // Full subtractor on the current LSBs and the running borrow.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    ai          = a_sh[0];
    bi          = b_sh[0];
    d           = ai ^ bi ^ borrow_ff;
    borrow_next = (~ai & bi) | (~(ai ^ bi) & borrow_ff);
    last_bit    = (cnt == CW'(WIDTH - 1));
    // Shift right and insert the new result bit at the MSB; written this way
    // so it also elaborates for WIDTH=1 where a slice [WIDTH-1:1] is empty.
    diff_shift             = diff_r >> 1;
    diff_shift[WIDTH-1]    = d;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;   // start here is ignored, not queued
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: operand shifters, borrow flip-flop, counter, result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, because diff/borrow are visible
    // outputs with defined reset values and a mid-run reset must clear them.
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      diff_r    <= '0;
      borrow_ff <= 1'b0;
      borrow_r  <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // diff_r/borrow_r are left alone so the last result stays readable.
          if (bus.start) begin
            a_sh      <= bus.a;
            b_sh      <= bus.b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
          end
        end
        RUN: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          borrow_ff <= borrow_next;
          diff_r    <= diff_shift;
          cnt       <= cnt + CW'(1);
          // Borrow out of the MSB is the unsigned a < b flag.
          if (last_bit) borrow_r <= borrow_next;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor. One instance at WIDTH=8 and one at
//   WIDTH=1 share clock and reset. Inputs are driven and outputs sampled on
//   the falling edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation from IDLE: checks latency (edges counted from the
  // accepting edge, inclusive), result, and the return to IDLE.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_diff, input logic exp_borrow);
    int n;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus8.start = 1'b0;
    check({tag, "_busy_run"}, {31'd0, bus8.busy}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, n, 32'd9);
    check({tag, "_diff"}, {24'd0, bus8.diff}, {24'd0, exp_diff});
    check({tag, "_borrow"}, {31'd0, bus8.borrow}, {31'd0, exp_borrow});
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, bus8.done}, 32'd0);
    check({tag, "_busy_idle"}, {31'd0, bus8.busy}, 32'd0);
    check({tag, "_diff_hold"}, {24'd0, bus8.diff}, {24'd0, exp_diff});
  endtask

  task automatic op1(input string tag, input logic a, input logic b,
                     input logic exp_diff, input logic exp_borrow);
    int n;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus1.done) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, n, 32'd2);
    check({tag, "_diff"}, {31'd0, bus1.diff}, {31'd0, exp_diff});
    check({tag, "_borrow"}, {31'd0, bus1.borrow}, {31'd0, exp_borrow});
    @(negedge clk);
    check({tag, "_busy_idle"}, {31'd0, bus1.busy}, 32'd0);
  endtask

  initial begin
    int          n;
    int          ndone;
    bit          seen_low;
    logic [7:0]  cap_diff;
    logic        cap_borrow;

    total = 0;
    bad   = 0;

    // Reset held for 3 cycles with a start request pending.
    rst_n      = 1'b0;
    bus8.start = 1'b1;
    bus8.a     = 8'hFF;
    bus8.b     = 8'h01;
    bus1.start = 1'b0;
    bus1.a     = 1'b0;
    bus1.b     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy",   {31'd0, bus8.busy},   32'd0);
      check("rst_done",   {31'd0, bus8.done},   32'd0);
      check("rst_diff",   {24'd0, bus8.diff},   32'd0);
      check("rst_borrow", {31'd0, bus8.borrow}, 32'd0);
    end
    rst_n      = 1'b1;
    bus8.start = 1'b0;
    @(negedge clk);
    check("rst_release_idle", {31'd0, bus8.busy}, 32'd0);

    // Basic and boundary vectors.
    op8("sub_5_3",   8'd5,   8'd3,   8'h02, 1'b0);
    op8("sub_3_5",   8'd3,   8'd5,   8'hFE, 1'b1);
    op8("sub_0_1",   8'h00,  8'h01,  8'hFF, 1'b1);
    op8("sub_ff_ff", 8'hFF,  8'hFF,  8'h00, 1'b0);
    op8("sub_80_7f", 8'h80,  8'h7F,  8'h01, 1'b0);

    // Start pulsed two cycles into a run must be ignored.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd10;
    bus8.b     = 8'd4;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd9;
    bus8.b     = 8'd9;
    @(negedge clk);
    bus8.start = 1'b0;
    ndone      = 0;
    cap_diff   = 8'h00;
    cap_borrow = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) begin
        ndone++;
        if (ndone == 1) begin
          cap_diff   = bus8.diff;
          cap_borrow = bus8.borrow;
        end
      end
      @(negedge clk);
    end
    check("ign_done_count", ndone, 32'd1);
    check("ign_diff",   {24'd0, cap_diff},   32'd6);
    check("ign_borrow", {31'd0, cap_borrow}, 32'd0);
    check("ign_idle",   {31'd0, bus8.busy},  32'd0);

    // Reset asserted at the 4th RUN edge of 0xAA - 0x55.
    bus8.start = 1'b1;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    @(posedge clk);                 // E0
    @(negedge clk);
    bus8.start = 1'b0;
    @(posedge clk);                 // E1
    @(posedge clk);                 // E2
    @(posedge clk);                 // E3
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);                 // E4, reset edge
    @(negedge clk);
    check("midrst_busy",   {31'd0, bus8.busy},   32'd0);
    check("midrst_done",   {31'd0, bus8.done},   32'd0);
    check("midrst_diff",   {24'd0, bus8.diff},   32'd0);
    check("midrst_borrow", {31'd0, bus8.borrow}, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check("midrst_no_done", ndone, 32'd0);

    // Start held high: second acceptance at the first IDLE edge. Operand
    // changes during the first run must not affect its result.
    bus8.start = 1'b1;
    bus8.a     = 8'd20;
    bus8.b     = 8'd7;
    @(posedge clk);                 // E0
    @(negedge clk);
    bus8.a     = 8'd1;
    bus8.b     = 8'd2;
    n          = 0;
    seen_low   = 1'b0;
    cap_diff   = 8'h00;
    cap_borrow = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus8.done) begin
        cap_diff   = bus8.diff;
        cap_borrow = bus8.borrow;
      end
      if (!bus8.busy) seen_low = 1'b1;
      else if (seen_low) break;
    end
    bus8.start = 1'b0;
    check("b2b_spacing", n, 32'd10);
    check("b2b_first_diff",   {24'd0, cap_diff},   32'h0D);
    check("b2b_first_borrow", {31'd0, cap_borrow}, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("b2b_second_latency", n, 32'd8);
    check("b2b_second_diff",   {24'd0, bus8.diff},   32'hFF);
    check("b2b_second_borrow", {31'd0, bus8.borrow}, 32'd1);
    @(negedge clk);

    // WIDTH=1: registered half subtractor, all four input pairs.
    op1("w1_0_0", 1'b0, 1'b0, 1'b0, 1'b0);
    op1("w1_1_0", 1'b1, 1'b0, 1'b1, 1'b0);
    op1("w1_0_1", 1'b0, 1'b1, 1'b1, 1'b1);
    op1("w1_1_1", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
